// File: rtl/phy_tx_serializer.sv
// PHY lane transmit serializer: parallel byte in, MSB-first bit stream out, comma sync after reset.
// Optional PHY_TX_BYTE_COUNT_EN adds a saturating byte_count of accepted data bytes.
module phy_tx_serializer #(
   parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
   parameter int unsigned SYNC_BYTES = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_req,
   output logic       data_out,
   output logic       sync_done
`ifdef PHY_TX_BYTE_COUNT_EN
   ,
   output logic [7:0] byte_count
`endif
);

   typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

   state_t     state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic [3:0] sync_cnt_q;
   logic       data_out_q;

   logic [7:0] load_byte_d;
   logic [3:0] sync_cnt_d;
   logic       load_edge;

   // During SYNC the host side is ignored entirely; only commas go out.
   always_comb begin
      load_byte_d = IDLE_CHAR;
      if (state_q == ACTIVE && valid_in) begin
         load_byte_d = data_in;
      end
   end

   assign sync_cnt_d = sync_cnt_q + 4'd1;
   assign load_edge  = (bit_cnt_q == 3'd0);

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state_q    <= SYNC;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         sync_cnt_q <= 4'd0;
         data_out_q <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_q + 3'd1;
         if (load_edge) begin
            data_out_q <= load_byte_d[7];
            shift_q    <= {load_byte_d[6:0], 1'b0};
            if (state_q == SYNC) begin
               sync_cnt_q <= sync_cnt_d;
               if (sync_cnt_d == 4'(SYNC_BYTES)) begin
                  state_q <= ACTIVE;
               end
            end
         end else begin
            data_out_q <= shift_q[7];
            shift_q    <= {shift_q[6:0], 1'b0};
         end
      end
   end

`ifdef PHY_TX_BYTE_COUNT_EN
   logic [7:0] byte_count_q;

   // Counts only real data loads; idle fill and sync commas are excluded.
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         byte_count_q <= 8'h00;
      end else if (load_edge && state_q == ACTIVE && valid_in && byte_count_q != 8'hFF) begin
         byte_count_q <= byte_count_q + 8'h01;
      end
   end

   assign byte_count = byte_count_q;
`endif

   assign data_req  = (state_q == ACTIVE) && load_edge && !reset;
   assign data_out  = data_out_q;
   assign sync_done = (state_q == ACTIVE);

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench for phy_tx_serializer: per-edge bit scoreboard, strobe and sync checks.
// Build with PHY_TX_BYTE_COUNT_EN defined to also check byte_count.
module tb_phy_tx_serializer;

   localparam logic [7:0] IDLE = 8'hBC;
   localparam int SB = 4;

   logic       clk_8f;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_req;
   logic       data_out;
   logic       sync_done;
`ifdef PHY_TX_BYTE_COUNT_EN
   logic [7:0] byte_count;
`endif

   phy_tx_serializer #(.IDLE_CHAR(IDLE), .SYNC_BYTES(SB)) dut (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .data_req  (data_req),
      .data_out  (data_out),
      .sync_done (sync_done)
`ifdef PHY_TX_BYTE_COUNT_EN
      ,
      .byte_count(byte_count)
`endif
   );

   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   edge_k   = 0;
   int   model_cnt = 0;
   logic exp_bits[$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_k, obs, exp);
      end
   endtask

   // Apply one reset edge and verify the cleared state on the following cycle.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk_8f);
      @(negedge clk_8f);
      check("rst_data_out", {7'd0, data_out}, 8'h00);
      check("rst_sync_done", {7'd0, sync_done}, 8'h00);
      check("rst_data_req", {7'd0, data_req}, 8'h00);
      reset = 1'b0;
      edge_k = 0;
      exp_bits.delete();
      model_cnt = 0;
`ifdef PHY_TX_BYTE_COUNT_EN
      check("rst_byte_count", byte_count, 8'h00);
`endif
   endtask

   // One non-reset edge: drive inputs, check the strobe, then the bit produced by that edge.
   task automatic step(input logic v, input logic [7:0] d);
      logic [7:0] sel;
      logic       exp_bit;
      valid_in = v;
      data_in  = d;
      #1;
      check("data_req", {7'd0, data_req}, {7'd0, (edge_k >= 8 * SB) && (edge_k % 8 == 0)});
      if (edge_k % 8 == 0) begin
         sel = (edge_k >= 8 * SB && v) ? d : IDLE;
         for (int i = 7; i >= 0; i--) exp_bits.push_back(sel[i]);
         if (edge_k >= 8 * SB && v && model_cnt < 255) model_cnt++;
      end
      @(posedge clk_8f);
      @(negedge clk_8f);
      exp_bit = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
      check("data_out", {7'd0, data_out}, {7'd0, exp_bit});
      check("sync_done", {7'd0, sync_done}, {7'd0, edge_k >= 8 * (SB - 1)});
`ifdef PHY_TX_BYTE_COUNT_EN
      check("byte_count", byte_count, 8'(model_cnt));
`endif
      edge_k++;
   endtask

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = 8'h00;
      repeat (2) @(posedge clk_8f);
      @(negedge clk_8f);

      // Phase A: valid data during SYNC is ignored, single byte, then idle fill.
      do_reset();
      for (int k = 0; k < 32; k++) step(1'b1, 8'h55);
      step(1'b1, 8'hA5);
      for (int k = 33; k < 40; k++) step(k[0], 8'($urandom));
      for (int k = 40; k < 64; k++) step(1'b0, 8'h00);

      // Phase B: back-to-back bytes with valid held high, comma-valued data last.
      do_reset();
      for (int k = 0; k < 32; k++) step(1'b0, 8'h00);
      for (int k = 0; k < 8; k++) step(1'b1, 8'h01);
      for (int k = 0; k < 8; k++) step(1'b1, 8'hFF);
      for (int k = 0; k < 8; k++) step(1'b1, 8'h80);
      for (int k = 0; k < 8; k++) step(1'b1, IDLE);
      for (int k = 0; k < 8; k++) step(1'b0, 8'h00);

      // Phase C: reset at edge 35 mid data byte, then full resync.
      do_reset();
      for (int k = 0; k < 35; k++) step(1'b1, 8'hC3);
      do_reset();
      for (int k = 0; k < 48; k++) step(1'b1, 8'h3C);

      // Phase D: 300 consecutive valid bytes then idle loads.
      do_reset();
      for (int k = 0; k < 32; k++) step(1'b0, 8'h00);
      for (int b = 0; b < 300; b++) begin
         for (int k = 0; k < 8; k++) step(1'b1, 8'(b * 37 + 11));
      end
      for (int k = 0; k < 24; k++) step(1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
